// File: rtl/loader.sv
// loader: streaming 3x3 window generator for the Sobel front end.
// Accepts one 8-bit pixel per enabled clock in raster order and presents the
// 3x3 neighbourhood around (row-1, col-1) once two full rows are buffered.
//
// Ports:
//   CLK                   rising-edge clock
//   Reset                 synchronous active-high reset (priority over Enable)
//   Enable                pixel valid; DataIn consumed on the CLK edge
//   DataIn[7:0]           pixel value
//   DataOut0..DataOut8    3x3 window, row-major; DataOut8 is the newest pixel
//   Out_Row[7:0]          row index of the window centre
//   Out_Column[7:0]       column index of the window centre
//   isReady               window outputs valid this cycle
//   isEnd                 last pixel of the frame accepted (sticky until Reset)
module loader #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] DataIn,
    output logic [7:0] DataOut0,
    output logic [7:0] DataOut1,
    output logic [7:0] DataOut2,
    output logic [7:0] DataOut3,
    output logic [7:0] DataOut4,
    output logic [7:0] DataOut5,
    output logic [7:0] DataOut6,
    output logic [7:0] DataOut7,
    output logic [7:0] DataOut8,
    output logic [7:0] Out_Row,
    output logic [7:0] Out_Column,
    output logic       isReady,
    output logic       isEnd
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [7:0] row;
    logic [7:0] col;

    // lineBuf1 holds row r-1, lineBuf0 holds row r-2, both indexed by column.
    logic [7:0] lineBuf0 [WIDTH];
    logic [7:0] lineBuf1 [WIDTH];

    logic [IDX_W-1:0] colIdx;
    logic [7:0]       above2;
    logic [7:0]       above1;
    logic             accept;
    logic             lastCol;
    logic             lastRow;
    logic             windowValid;

    assign colIdx      = col[IDX_W-1:0];
    assign above2      = lineBuf0[colIdx];
    assign above1      = lineBuf1[colIdx];
    assign accept      = Enable && !isEnd;
    assign lastCol     = (col == 8'(WIDTH - 1));
    assign lastRow     = (row == 8'(HEIGHT - 1));
    assign windowValid = (row >= 8'd2) && (col >= 8'd2);

    // Line buffers: read-before-write per column. Contents are not reset since
    // a column is always rewritten before it can reach a valid window.
    always_ff @(posedge CLK) begin
        if (!Reset && accept) begin
            lineBuf0[colIdx] <= above1;
            lineBuf1[colIdx] <= DataIn;
        end
    end

    // Position counters, window shift, coordinates and flags.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            row        <= 8'd0;
            col        <= 8'd0;
            DataOut0   <= 8'd0;
            DataOut1   <= 8'd0;
            DataOut2   <= 8'd0;
            DataOut3   <= 8'd0;
            DataOut4   <= 8'd0;
            DataOut5   <= 8'd0;
            DataOut6   <= 8'd0;
            DataOut7   <= 8'd0;
            DataOut8   <= 8'd0;
            Out_Row    <= 8'd0;
            Out_Column <= 8'd0;
            isReady    <= 1'b0;
            isEnd      <= 1'b0;
        end else if (accept) begin
            if (lastCol) begin
                col <= 8'd0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end

            // Shift each window row left; new right column comes from the
            // two line buffers and the incoming pixel.
            DataOut0 <= DataOut1;
            DataOut1 <= DataOut2;
            DataOut2 <= above2;
            DataOut3 <= DataOut4;
            DataOut4 <= DataOut5;
            DataOut5 <= above1;
            DataOut6 <= DataOut7;
            DataOut7 <= DataOut8;
            DataOut8 <= DataIn;

            if (windowValid) begin
                isReady    <= 1'b1;
                Out_Row    <= row - 8'd1;
                Out_Column <= col - 8'd1;
            end else begin
                isReady <= 1'b0;
            end

            if (lastRow && lastCol) begin
                isEnd <= 1'b1;
            end
        end else begin
            isReady <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loader.sv
// Self-checking bench for loader (256x256). A frame-level model stores every
// accepted pixel in an image array and derives the expected window, centre
// coordinates and flags directly from image positions.
module tb_loader;

    localparam int W = 256;
    localparam int H = 256;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic [7:0] DataIn = 8'd0;
    logic [7:0] DataOut0, DataOut1, DataOut2, DataOut3, DataOut4;
    logic [7:0] DataOut5, DataOut6, DataOut7, DataOut8;
    logic [7:0] Out_Row, Out_Column;
    logic       isReady, isEnd;

    loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .DataIn(DataIn),
        .DataOut0(DataOut0), .DataOut1(DataOut1), .DataOut2(DataOut2),
        .DataOut3(DataOut3), .DataOut4(DataOut4), .DataOut5(DataOut5),
        .DataOut6(DataOut6), .DataOut7(DataOut7), .DataOut8(DataOut8),
        .Out_Row(Out_Row), .Out_Column(Out_Column),
        .isReady(isReady), .isEnd(isEnd)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nPass   = 0;

    // Behavioural model state.
    logic [7:0] img [W*H];
    int         k = 0;
    bit         ended = 1'b0;
    int         expReady = 0, expEnd = 0, expRow = 0, expCol = 0;
    int         expWin [9];
    bit         winKnown = 1'b0;
    bit         checkOn = 1'b0;

    logic [7:0] dOut [9];
    always_comb begin
        dOut[0] = DataOut0; dOut[1] = DataOut1; dOut[2] = DataOut2;
        dOut[3] = DataOut3; dOut[4] = DataOut4; dOut[5] = DataOut5;
        dOut[6] = DataOut6; dOut[7] = DataOut7; dOut[8] = DataOut8;
    end

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] pat(input int idx);
        return 8'((7 * (idx / W) + (idx % W)) % 256);
    endfunction

    // Frame-level model: window = image neighbourhood around (r-1, c-1).
    task automatic modelStep(input logic rst, input logic en, input logic [7:0] din);
        int r, c;
        if (rst) begin
            k = 0; ended = 1'b0;
            expReady = 0; expEnd = 0; expRow = 0; expCol = 0;
            for (int i = 0; i < 9; i++) expWin[i] = 0;
            winKnown = 1'b1;
            checkOn = 1'b1;
        end else if (en && !ended) begin
            r = k / W;
            c = k % W;
            img[16'(k)] = din;
            if (r >= 2 && c >= 2) begin
                expReady = 1; expRow = r - 1; expCol = c - 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        expWin[3*i+j] = int'(img[16'((r - 2 + i) * W + c - 2 + j)]);
                winKnown = 1'b1;
            end else begin
                expReady = 0;
                winKnown = 1'b0;
            end
            if (k == W * H - 1) begin
                ended = 1'b1;
                expEnd = 1;
            end
            k++;
        end else begin
            expReady = 0;
        end
    endtask

    // Compare process: every cycle on the falling edge.
    always @(negedge CLK) begin
        if (checkOn) begin
            check("isReady", int'(isReady), expReady);
            check("isEnd", int'(isEnd), expEnd);
            check("Out_Row", int'(Out_Row), expRow);
            check("Out_Column", int'(Out_Column), expCol);
            if (winKnown)
                for (int i = 0; i < 9; i++)
                    check($sformatf("DataOut%0d", i), int'(dOut[i]), expWin[i]);
        end
    end

    task automatic cycle(input logic rst, input logic en, input logic [7:0] din);
        Reset = rst; Enable = en; DataIn = din;
        @(posedge CLK);
        modelStep(rst, en, din);
        #1;
    endtask

    initial begin
        int firstReady;
        int readyCount;
        logic [7:0] d;

        // Reset held with Enable=1 and DataIn=FF.
        cycle(1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 1'b1, 8'hFF);
        check("rst_DataOut8", int'(DataOut8), 0);
        check("rst_isEnd", int'(isEnd), 0);
        check("rst_isReady", int'(isReady), 0);

        // Random pixels with random gaps, then mid-frame reset after 1000.
        d = 8'($urandom);
        cycle(1'b0, 1'b1, d);
        check("first_pixel_DataOut8", int'(DataOut8), int'(d));
        for (int i = 1; i < 1000; i++) begin
            if ($urandom_range(0, 15) == 0) cycle(1'b0, 1'b0, 8'($urandom));
            cycle(1'b0, 1'b1, 8'($urandom));
        end
        cycle(1'b1, 1'b1, 8'($urandom));
        check("midrst_isEnd", int'(isEnd), 0);
        check("midrst_isReady", int'(isReady), 0);
        check("midrst_DataOut4", int'(DataOut4), 0);
        check("midrst_Out_Row", int'(Out_Row), 0);

        // Full frame of the 7r+c pattern with random Enable gaps.
        firstReady = -1;
        readyCount = 0;
        for (int idx = 0; idx < W * H; idx++) begin
            if ($urandom_range(0, 15) == 0) cycle(1'b0, 1'b0, 8'($urandom));
            cycle(1'b0, 1'b1, pat(idx));
            if (isReady) begin
                readyCount++;
                if (firstReady < 0) firstReady = idx + 1;
            end
            if (idx == 514) begin
                check("w514_isReady", int'(isReady), 1);
                check("w514_Out_Row", int'(Out_Row), 1);
                check("w514_Out_Column", int'(Out_Column), 1);
                check("w514_DataOut0", int'(DataOut0), 0);
                check("w514_DataOut4", int'(DataOut4), 8);
                check("w514_DataOut8", int'(DataOut8), 16);
            end
            if (idx == 515) begin
                check("w515_Out_Column", int'(Out_Column), 2);
                check("w515_DataOut0", int'(DataOut0), 1);
            end
            if (idx == 768 || idx == 769)
                check("wrap_isReady_low", int'(isReady), 0);
            if (idx == 770) begin
                check("wrap_isReady", int'(isReady), 1);
                check("wrap_Out_Row", int'(Out_Row), 2);
                check("wrap_Out_Column", int'(Out_Column), 1);
                check("wrap_DataOut0", int'(DataOut0), 7);
                check("wrap_DataOut8", int'(DataOut8), 23);
            end
            if (idx == 999) begin
                for (int g = 0; g < 5; g++) begin
                    cycle(1'b0, 1'b0, 8'($urandom));
                    check("gap_isReady", int'(isReady), 0);
                    check("gap_Out_Row", int'(Out_Row), 2);
                    check("gap_Out_Column", int'(Out_Column), 230);
                    check("gap_DataOut0", int'(DataOut0), 236);
                    check("gap_DataOut4", int'(DataOut4), 244);
                    check("gap_DataOut8", int'(DataOut8), 252);
                end
            end
            if (idx == W * H - 2)
                check("pre_end_isEnd", int'(isEnd), 0);
        end
        check("end_isEnd", int'(isEnd), 1);
        check("end_isReady", int'(isReady), 1);
        check("end_Out_Row", int'(Out_Row), 254);
        check("end_Out_Column", int'(Out_Column), 254);
        check("end_DataOut8", int'(DataOut8), 248);
        check("first_ready_pixel", firstReady, 515);
        check("ready_count", readyCount, (W - 2) * (H - 2));

        // Pixels after end of frame are ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom));
            check("post_isEnd", int'(isEnd), 1);
            check("post_isReady", int'(isReady), 0);
            check("post_DataOut8", int'(DataOut8), 248);
            check("post_Out_Column", int'(Out_Column), 254);
        end

        cycle(1'b1, 1'b0, 8'd0);
        check("final_rst_isEnd", int'(isEnd), 0);
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/loader.md
# loader

Streaming 3×3 window generator at the front of the Sobel edge-detection pipeline. It accepts one 8-bit grayscale pixel per enabled clock in raster order (row 0 col 0 first) for a WIDTH×HEIGHT image. Two internal line buffers let it present the full 3×3 neighbourhood, plus the neighbourhood's centre coordinates, to the downstream gradient stage. It flags each valid window and end of frame.

## Interface
- WIDTH, 256, pixels per row (max 256; coordinates are 8 bits)
- HEIGHT, 256, rows per frame (max 256)
- CLK  in  1  rising-edge clock; one clock domain
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  pixel-valid; DataIn is consumed on each rising CLK edge where Enable=1
- DataIn  in  8  pixel value
- DataOut0..DataOut8  out  8 each  3×3 window, row-major: DataOut0 = top-left, DataOut2 = top-right, DataOut4 = centre, DataOut8 = bottom-right (newest pixel)
- Out_Row  out  8  row index of window centre
- Out_Column  out  8  column index of window centre
- isReady  out  1  window outputs valid this cycle
- isEnd  out  1  last pixel of frame has been accepted (sticky)

## Operation
- Internal counters row r and col c give the position of the next pixel to be accepted. Both reset to 0.
- On an accepted pixel at (r,c):
  - c increments. At WIDTH-1, c wraps to 0 and r increments.
  - Line buffer LB1 (row r-1) and LB0 (row r-2) are WIDTH-deep. They are implemented as shift registers or as RAM with a shared col-indexed pointer.
  - The read values at column c are LB0[c] = P(r-2,c) and LB1[c] = P(r-1,c).
  - Write-back: LB0[c] ← LB1[c] and LB1[c] ← DataIn.
- Window update on each accepted pixel:
  - Each window row shifts left one column (DataOut0←DataOut1←DataOut2, etc.).
  - The new right column is {DataOut2, DataOut5, DataOut8} = {P(r-2,c), P(r-1,c), DataIn}.
- Validity and coordinates:
  - The window is valid when the accepted pixel has r≥2 and c≥2.
  - On that edge, isReady←1, Out_Row←r-1, Out_Column←c-1.
  - Otherwise isReady←0, and Out_Row/Out_Column hold their values.
  - For c<2 the window holds stale columns from the previous row; isReady is 0 for those pixels.
- Enable=0: no counters, buffers, window registers or coordinates change. isReady←0.
- End of frame:
  - Accepting pixel (HEIGHT-1, WIDTH-1) sets isEnd←1. isEnd stays 1 until Reset.
  - While isEnd=1, further pixels are ignored: no state changes and isReady←0.
- Reset:
  - All outputs are 0: DataOut0..8, Out_Row, Out_Column, isReady, isEnd.
  - r, c and the window registers are cleared.
  - Line-buffer contents need not be cleared; they are never exposed before being overwritten.
  - Reset has priority over Enable.
  - Reset asserted mid-frame aborts the frame; the next accepted pixel is (0,0).

## Timing
- All outputs are registered and update on the same rising edge that accepts the pixel. Latency is 1 clock from DataIn to DataOut8.
- The first isReady occurs on the edge accepting pixel index 2·WIDTH+2 (index 514 for 256×256).
- isReady is high for exactly one cycle per accepted valid pixel. Back-to-back Enable produces consecutive isReady cycles within a row.
- There are (WIDTH-2)·(HEIGHT-2) isReady cycles per frame.
- isEnd rises on the edge accepting the last pixel. The final window is asserted on that same edge: isReady=1, centre (HEIGHT-2, WIDTH-2).
- No backpressure: downstream must consume each window in the isReady cycle.

## Test plan
- Reset: hold Reset=1 for 2 clocks with Enable=1 and DataIn=8'hFF -> all outputs 0, no counter advance. After release, the first accepted pixel is (0,0).
- Window contents: stream P(r,c)=(7r+c) mod 256 continuously. At the edge accepting index 514, require isReady=1, Out_Row=1, Out_Column=1, DataOut0=0, DataOut4=8, DataOut8=16. The next edge requires Out_Column=2 and DataOut0=1.
- Row wrap: pixels (3,0) and (3,1) -> isReady=0. Pixel (3,2) -> isReady=1, Out_Row=2, Out_Column=1, DataOut0=P(1,0)=7, DataOut8=P(3,2)=23.
- Enable gaps: deassert Enable for 5 cycles mid-row -> isReady=0 and DataOut/Out_Row/Out_Column unchanged. On resume, the window continues exactly as without the gap.
- End of frame: after pixel index 65535, require isEnd=1, isReady=1, Out_Row=254, Out_Column=254, DataOut8=248. With further Enable cycles, isEnd stays 1, isReady=0 and outputs are frozen.
- Mid-frame reset: assert Reset after 1000 pixels -> outputs 0 and isEnd=0. Re-streaming gives the first isReady again at the 515th accepted pixel with correct values.
